exec_sequencer: RTL and testbench

Execution sequencer for the 8-bit SAP-style CPU. Generates the one-hot T-state ring that the microcode `control_block` decodes into bus-enable and register-load signals. Adds the run control the bare ring counter lacks: free-run, single-instruction stepping, early instruction termination, HLT, and a retired-instruction counter. It sits between the top-level user inputs (`ui_in`) and the control decode, replacing any free-running T-state counter.

---
 rtl/exec_sequencer_pkg.sv | 24 ++
 rtl/exec_sequencer_if.sv | 44 ++++
 rtl/exec_sequencer_sat_counter.sv | 23 ++
 rtl/exec_sequencer.sv | 104 ++++++++++
 tb/tb_exec_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer.
//   seq_state_t  : run-control state (IDLE, RUN, HALT)
//   NUM_T_DEF    : default number of T-states per instruction
//   FETCH_T_DEF  : default number of fetch T-states
//   T1..T6       : bit index of each T-state within the one-hot ring
package exec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    localparam int NUM_T_DEF   = 6;
    localparam int FETCH_T_DEF = 3;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

endpackage

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the user inputs + microcode decode and the
// execution sequencer.
//   Inputs to the sequencer : run_en, step_mode, step, end_early, halt_op
//   Outputs from sequencer  : tstate, fetch, instr_done, halted, busy,
//                             instr_cnt, state (FSM state for observation)
//
// Control contract: run_en and step_mode are levels sampled on every rising
// clk edge; step is a level whose rising edge (relative to the previous
// cycle) requests one instruction while IDLE and is dropped otherwise;
// end_early/halt_op are qualified by the current tstate and only honoured
// after the fetch T-states; instr_done marks the last cycle of an
// instruction and the retire happens on the following clk edge.
interface exec_sequencer_if
    import exec_seq_pkg::*;
#(
    parameter int NUM_T = NUM_T_DEF,
    parameter int CNT_W = 16
) ();

    logic             run_en;
    logic             step_mode;
    logic             step;
    logic             end_early;
    logic             halt_op;

    logic [NUM_T-1:0] tstate;
    logic             fetch;
    logic             instr_done;
    logic             halted;
    logic             busy;
    logic [CNT_W-1:0] instr_cnt;
    seq_state_t       state;

    modport master (
        output run_en, step_mode, step, end_early, halt_op,
        input  tstate, fetch, instr_done, halted, busy, instr_cnt, state
    );

    modport slave (
        input  run_en, step_mode, step, end_early, halt_op,
        output tstate, fetch, instr_done, halted, busy, instr_cnt, state
    );

endinterface

// File: rtl/exec_sequencer_sat_counter.sv
// Saturating up-counter for event counting.
//   clk : clock
//   rst : synchronous active-high clear
//   inc : count one event on this edge
//   q   : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: drives the one-hot T-state ring consumed by the
// microcode decode and adds run control (free-run, single-instruction step,
// early termination, HLT) plus a saturating retired-instruction counter.
//   clk, rst : clock and synchronous active-high reset
//   bus      : exec_sequencer_if slave modport (run controls in, ring and
//              status out)
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int NUM_T   = NUM_T_DEF,
    parameter int FETCH_T = FETCH_T_DEF,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             rst,
    exec_sequencer_if.slave bus
);

    localparam logic [NUM_T-1:0] T1_HOT = NUM_T'(1) << T1;

    seq_state_t       state_q;
    logic [NUM_T-1:0] tstate_q;
    logic             step_q;

    logic step_edge;
    logic start_req;
    logic past_fetch;
    logic last_t;
    logic halt_end;
    logic end_now;
    logic chain;

    assign step_edge  = bus.step & ~step_q;
    assign start_req  = bus.step_mode ? step_edge : bus.run_en;

    // Any ring bit above the fetch window means decode may end the instruction.
    assign past_fetch = |tstate_q[NUM_T-1:FETCH_T];
    assign last_t     = tstate_q[NUM_T-1];

    assign halt_end   = (state_q == RUN) && bus.halt_op && past_fetch;
    assign end_now    = (state_q == RUN) &&
                        (halt_end || (bus.end_early && past_fetch) || last_t);

    // Continue straight into the next fetch only in free-run mode.
    assign chain      = !bus.step_mode && bus.run_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tstate_q <= '0;
            step_q   <= 1'b0;
        end else begin
            step_q <= bus.step;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        state_q  <= RUN;
                        tstate_q <= T1_HOT;
                    end
                end
                RUN: begin
                    if (end_now) begin
                        if (halt_end) begin
                            state_q  <= HALT;
                            tstate_q <= '0;
                        end else if (chain) begin
                            tstate_q <= T1_HOT;
                        end else begin
                            state_q  <= IDLE;
                            tstate_q <= '0;
                        end
                    end else begin
                        tstate_q <= tstate_q << 1;
                    end
                end
                HALT: begin
                    tstate_q <= '0;
                end
                default: begin
                    state_q  <= IDLE;
                    tstate_q <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.instr_done),
        .q   (bus.instr_cnt)
    );

    // A reset landing on the final T-state must not retire that instruction.
    assign bus.instr_done = end_now & ~rst;
    assign bus.tstate     = tstate_q;
    assign bus.fetch      = |tstate_q[FETCH_T-1:0];
    assign bus.busy       = (state_q == RUN);
    assign bus.halted     = (state_q == HALT);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;
    import exec_seq_pkg::*;

    localparam int NUM_T   = 6;
    localparam int FETCH_T = 3;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_sequencer_if #(.NUM_T(NUM_T), .CNT_W(CNT_W)) bus ();
    exec_sequencer_if #(.NUM_T(NUM_T), .CNT_W(4))     b2 ();

    exec_sequencer #(.NUM_T(NUM_T), .FETCH_T(FETCH_T), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exec_sequencer #(.NUM_T(NUM_T), .FETCH_T(FETCH_T), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = running, 2 = halted;
    // m_t = current T number (1..NUM_T) or 0 when not running.
    int          m_mode = 0;
    int          m_t    = 0;
    int unsigned m_cnt  = 0;
    bit          m_step_prev = 1'b0;

    always @(posedge clk) begin
        bit edge_seen;
        bit ends;
        bit halts;
        if (rst) begin
            m_mode = 0; m_t = 0; m_cnt = 0; m_step_prev = 1'b0;
        end else begin
            edge_seen   = bus.step && !m_step_prev;
            m_step_prev = bus.step;
            if (m_mode == 0) begin
                if (bus.step_mode ? edge_seen : bus.run_en) begin
                    m_mode = 1; m_t = 1;
                end
            end else if (m_mode == 1) begin
                halts = (m_t > FETCH_T) && bus.halt_op;
                ends  = (m_t == NUM_T) || halts || ((m_t > FETCH_T) && bus.end_early);
                if (ends) begin
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (halts) begin
                        m_mode = 2; m_t = 0;
                    end else if (!bus.step_mode && bus.run_en) begin
                        m_t = 1;
                    end else begin
                        m_mode = 0; m_t = 0;
                    end
                end else begin
                    m_t = m_t + 1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (model_on) begin
                logic [31:0] exp_t;
                bit exp_done;
                seq_state_t exp_state;
                exp_t = (m_t == 0) ? 32'd0 : (32'd1 << (m_t - 1));
                exp_done = (m_mode == 1) && !rst &&
                           ((m_t == NUM_T) || ((m_t > FETCH_T) && (bus.end_early || bus.halt_op)));
                exp_state = (m_mode == 0) ? IDLE : ((m_mode == 1) ? RUN : HALT);
                chk("cmp_tstate", 32'(bus.tstate), exp_t);
                chk("cmp_fetch", 32'(bus.fetch), 32'((m_t >= 1) && (m_t <= FETCH_T)));
                chk("cmp_busy", 32'(bus.busy), 32'(m_mode == 1));
                chk("cmp_halted", 32'(bus.halted), 32'(m_mode == 2));
                chk("cmp_done", 32'(bus.instr_done), 32'(exp_done));
                chk("cmp_cnt", 32'(bus.instr_cnt), m_cnt);
                chk("cmp_state", 32'(bus.state), 32'(exp_state));
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus.run_en = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
        bus.end_early = 1'b0; bus.halt_op = 1'b0;
        b2.run_en = 1'b0; b2.step_mode = 1'b0; b2.step = 1'b0;
        b2.end_early = 1'b0; b2.halt_op = 1'b0;

        // Reset for two edges.
        @(negedge clk);
        model_on = 1'b1;
        #2;
        chk("rst_tstate", 32'(bus.tstate), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_fetch", 32'(bus.fetch), 32'd0);
        chk("rst_cnt", 32'(bus.instr_cnt), 32'd0);
        chk("rst_done", 32'(bus.instr_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.run_en = 1'b1;

        // Free-run: two full instructions back to back.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            chk("free_tstate", 32'(bus.tstate), 32'd1 << (i % 6));
            chk("free_fetch", 32'(bus.fetch), 32'((i % 6) < 3));
            chk("free_done", 32'(bus.instr_done), 32'((i % 6) == 5));
        end
        bus.run_en = 1'b0;
        @(negedge clk); #2;
        chk("free_idle_tstate", 32'(bus.tstate), 32'd0);
        chk("free_idle_busy", 32'(bus.busy), 32'd0);
        chk("free_cnt", 32'(bus.instr_cnt), 32'd2);

        // Early end ignored in fetch, honoured at T4; then HLT at T5.
        bus.run_en = 1'b1;
        @(negedge clk); #2;
        chk("early_t1", 32'(bus.tstate), 32'd1);
        @(negedge clk); bus.end_early = 1'b1; #2;
        chk("early_t2_done", 32'(bus.instr_done), 32'd0);
        @(negedge clk); bus.end_early = 1'b0; #2;
        chk("early_t3", 32'(bus.tstate), 32'd4);
        @(negedge clk); bus.end_early = 1'b1; #2;
        chk("early_t4_done", 32'(bus.instr_done), 32'd1);
        @(negedge clk); bus.end_early = 1'b0; #2;
        chk("early_next_t1", 32'(bus.tstate), 32'd1);
        chk("early_cnt", 32'(bus.instr_cnt), 32'd3);
        repeat (4) @(negedge clk);
        bus.halt_op = 1'b1; #2;
        chk("halt_t5", 32'(bus.tstate), 32'd16);
        chk("halt_t5_done", 32'(bus.instr_done), 32'd1);
        @(negedge clk); bus.halt_op = 1'b0; #2;
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_tstate", 32'(bus.tstate), 32'd0);
        chk("halt_busy", 32'(bus.busy), 32'd0);
        chk("halt_cnt", 32'(bus.instr_cnt), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.run_en = i[0]; bus.step = ~i[0]; bus.step_mode = i[1];
            #2;
            chk("halt_hold_tstate", 32'(bus.tstate), 32'd0);
            chk("halt_hold_halted", 32'(bus.halted), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1; bus.run_en = 1'b0; bus.step = 1'b0; bus.step_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0; #2;
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        chk("halt_rst_cnt", 32'(bus.instr_cnt), 32'd0);

        // Step mode: step held high gives exactly one instruction.
        @(negedge clk);
        bus.step_mode = 1'b1; bus.step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            chk("step_tstate", 32'(bus.tstate), (i < 6) ? (32'd1 << i) : 32'd0);
        end
        chk("step_cnt1", 32'(bus.instr_cnt), 32'd1);
        @(negedge clk); bus.step = 1'b0;
        @(negedge clk); bus.step = 1'b1;
        @(negedge clk); bus.step = 1'b0; #2;
        chk("step2_t1", 32'(bus.tstate), 32'd1);
        @(negedge clk); bus.step = 1'b1; #2;
        chk("step2_t2", 32'(bus.tstate), 32'd2);
        for (int j = 2; j < 6; j++) begin
            @(negedge clk); #2;
            chk("step2_run", 32'(bus.tstate), 32'd1 << j);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #2;
            chk("step2_idle", 32'(bus.tstate), 32'd0);
        end
        chk("step_cnt2", 32'(bus.instr_cnt), 32'd2);
        bus.step = 1'b0; bus.step_mode = 1'b0;

        // run_en dropped at T2: instruction completes, then IDLE.
        @(negedge clk); bus.run_en = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.run_en = 1'b0; #2;
        chk("drop_t2", 32'(bus.tstate), 32'd2);
        for (int j = 2; j < 6; j++) begin
            @(negedge clk); #2;
            chk("drop_run", 32'(bus.tstate), 32'd1 << j);
            chk("drop_done", 32'(bus.instr_done), 32'(j == 5));
        end
        @(negedge clk); #2;
        chk("drop_idle", 32'(bus.tstate), 32'd0);
        chk("drop_cnt", 32'(bus.instr_cnt), 32'd3);

        // Reset mid-instruction at T3, then at T6.
        @(negedge clk); bus.run_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; #2;
        chk("rst_t3_tstate", 32'(bus.tstate), 32'd4);
        @(negedge clk); rst = 1'b0; bus.run_en = 1'b0; #2;
        chk("rst_t3_idle", 32'(bus.tstate), 32'd0);
        chk("rst_t3_cnt", 32'(bus.instr_cnt), 32'd0);
        @(negedge clk); bus.run_en = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; #2;
        chk("rst_t6_tstate", 32'(bus.tstate), 32'd32);
        chk("rst_t6_done", 32'(bus.instr_done), 32'd0);
        @(negedge clk); rst = 1'b0; bus.run_en = 1'b0; #2;
        chk("rst_t6_cnt", 32'(bus.instr_cnt), 32'd0);
        chk("rst_t6_idle", 32'(bus.tstate), 32'd0);

        // 4-bit counter saturates after 15 retirements.
        @(negedge clk); b2.run_en = 1'b1;
        repeat (90) @(negedge clk);
        #2;
        chk("sat_cnt14", 32'(b2.instr_cnt), 32'd14);
        chk("sat_t6_done", 32'(b2.instr_done), 32'd1);
        @(negedge clk); #2;
        chk("sat_cnt15", 32'(b2.instr_cnt), 32'd15);
        repeat (12) @(negedge clk);
        #2;
        chk("sat_cnt17", 32'(b2.instr_cnt), 32'd15);
        chk("sat_tstate", 32'(b2.tstate), 32'd1);
        b2.run_en = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        chk("sat_idle", 32'(b2.tstate), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
